binarization: RTL and testbench
===============================

Name: binarization

Overview:
- Self-contained image thresholding block with an internal 8-bit greyscale frame buffer.
- An init command fills the buffer with a deterministic test image.
- A binarize command streams every pixel out as a 1-bit result (pixel vs. threshold) with its address.
- Sits between a frame source/test harness and downstream binary-image consumers; status goes to two board LEDs.

Parameters:
- ADDR_W, 16, pixel address width; frame holds N = 2**ADDR_W pixels (default 256x256 = 65536); must be >= 9.

Ports:
- bin_clk  input  1  single system clock; all logic on rising edge.
- bin_rst  input  1  synchronous, active-high reset.
- int_ctrl  input  1  init command; rising edge starts buffer fill.
- bin_ctrl  input  1  binarize command; rising edge starts output pass.
- thres_length  input  8  threshold value (unsigned).
- pixel_address  output  ADDR_W  address of the pixel currently presented on bin_data.
- bin_data  output  1  binarized pixel.
- condition_led  output  2  state indicator.

Behaviour:
- Clocking/reset: one clock (bin_clk); reset is synchronous and active-high (bin_rst).
- Reset values:
  - state IDLE; condition_led=00; pixel_address=0; bin_data=0.
  - Edge-detect registers=0; address counter=0.
  - Buffer contents are not cleared.
- Commands:
  - Both commands are rising-edge detected against a registered copy of the input, so a multi-cycle-high pulse counts once.
  - Edges arriving while busy (INIT or BIN) are ignored.
- States and condition_led encoding: IDLE=00, INIT=01, BIN=10, READY=11.
- Transitions:
  - IDLE: int_ctrl edge -> INIT. bin_ctrl edge is ignored (buffer not yet valid).
  - INIT: one write per cycle to addresses 0..N-1. After writing N-1 -> READY. Fill takes exactly N cycles.
  - Init pattern: mem[a] = (a[7:0] + a[15:8]) mod 256 (upper byte = a[ADDR_W-1:8] zero-extended/truncated to 8 bits).
  - READY: int_ctrl edge -> INIT (refill); bin_ctrl edge -> BIN.
  - If both edges occur in the same cycle in READY, int_ctrl wins.
  - BIN: thres_length is latched on entry and held for the whole pass.
    - Read address runs 0..N-1, one per cycle; the synchronous RAM read has 1-cycle latency.
    - Output register: pixel_address = read address delayed 1 cycle; bin_data = (mem value >= latched threshold).
    - The output pair is valid in the N consecutive cycles starting one cycle after the first read.
    - BIN lasts N+1 cycles, then -> READY.
- Outputs outside valid BIN output cycles: pixel_address=0, bin_data=0.
- Threshold edges: thres=0 -> all ones; thres=255 -> only pixels equal to 255 produce 1.
- Counter wrap: the address counter stops at N-1 and never wraps into a second pass.
- Reset mid-operation: on the next edge, abort to IDLE with reset values. The buffer keeps partial contents; bin_ctrl stays ignored until a fresh init completes.

Optional Feature:
- Macro BIN_INVERT_EN.
  - Defined: bin_data = (pixel < latched threshold), i.e. dark pixels output 1.
  - Undefined: bin_data = (pixel >= latched threshold).
- Timing, states and LEDs are identical either way.

Test Plan:
- Reset then idle: hold bin_rst 3 cycles -> condition_led=00, pixel_address=0, bin_data=0; a bin_ctrl pulse in IDLE leaves condition_led=00.
- Init: int_ctrl high 10 cycles -> condition_led=01 for exactly 65536 cycles, then 11; the long pulse triggers only one fill.
- Binarize at thres_length=40:
  - bin_ctrl 10-cycle pulse -> condition_led=10 for 65537 cycles, then 11.
  - pixel_address steps 0..65535, one per cycle.
  - bin_data=0 at address 0 (value 0), 1 at address 40 (value 40), 0 at address 39, 0 at address 0x0100+38 (value 39), 1 at address 0x0100+39 (value 40).
- Threshold latching: change thres_length from 40 to 200 mid-pass -> results for the rest of the pass still use 40.
- Threshold extremes: thres=0 -> bin_data=1 for all 65536 pixels; thres=255 -> 1 only where the pattern value is 255 (e.g. address 0x00FF).
- Busy/reset: int_ctrl edge during BIN is ignored; bin_rst asserted mid-BIN -> next cycle condition_led=00 and outputs 0; with BIN_INVERT_EN and thres=40, address 39 -> 1 and address 40 -> 0.

Source files
------------

// File: rtl/binarization.sv
// Image thresholding block: fills an internal 8-bit frame buffer with a test pattern,
// then streams each pixel out as a 1-bit result. Define BIN_INVERT_EN to output 1 for dark pixels.
module binarization #(
  parameter int ADDR_W = 16
) (
  input  logic              bin_clk,
  input  logic              bin_rst,
  input  logic              int_ctrl,
  input  logic              bin_ctrl,
  input  logic [7:0]        thres_length,
  output logic [ADDR_W-1:0] pixel_address,
  output logic              bin_data,
  output logic [1:0]        condition_led
);

  localparam int N = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INIT  = 2'b01,
    BIN   = 2'b10,
    READY = 2'b11
  } state_t;

  state_t state, next_state;

  logic              int_q, bin_q;
  logic              int_rise, bin_rise;
  logic [ADDR_W-1:0] addr;
  logic              rd_done;
  logic              mem_we, rd_en;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        thres_q;
  logic [7:0]        rd_data;
  logic [7:0]        hi_byte;
  logic [7:0]        init_pix;
  logic              hit;

  logic [7:0] mem [N];

  assign int_rise = int_ctrl & ~int_q;
  assign bin_rise = bin_ctrl & ~bin_q;

  // Upper address byte, zero-extended when the frame is narrower than 16 address bits.
  if (ADDR_W >= 16) begin : g_hi_full
    assign hi_byte = addr[15:8];
  end else begin : g_hi_ext
    assign hi_byte = {{(16 - ADDR_W){1'b0}}, addr[ADDR_W-1:8]};
  end

  assign init_pix = addr[7:0] + hi_byte;

  always_ff @(posedge bin_clk) begin
    if (bin_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    next_state = state;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    case (state)
      IDLE:  if (int_rise) next_state = INIT;
      INIT: begin
        mem_we = 1'b1;
        if (addr == '1) next_state = READY;
      end
      READY: begin
        if (int_rise)      next_state = INIT;
        else if (bin_rise) next_state = BIN;
      end
      BIN: begin
        // One extra cycle after the last read drains the read pipeline.
        if (rd_done) next_state = READY;
        else         rd_en = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge bin_clk) begin
    if (bin_rst) begin
      int_q     <= 1'b0;
      bin_q     <= 1'b0;
      addr      <= '0;
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      thres_q   <= '0;
    end else begin
      int_q     <= int_ctrl;
      bin_q     <= bin_ctrl;
      out_valid <= rd_en;
      out_addr  <= rd_en ? addr : '0;
      if (state != BIN && next_state == BIN) thres_q <= thres_length;
      if (state != next_state) begin
        addr    <= '0;
        rd_done <= 1'b0;
      end else if (mem_we || rd_en) begin
        // Counter parks on the last address instead of wrapping into a second pass.
        if (addr == '1) rd_done <= rd_en;
        else            addr    <= addr + ADDR_W'(1);
      end
    end
  end

  // NOTE: the frame buffer and its read register are deliberately not reset so they map to block RAM.
  always_ff @(posedge bin_clk) begin
    if (mem_we && !bin_rst) mem[addr] <= init_pix;
    if (rd_en)              rd_data   <= mem[addr];
  end

`ifdef BIN_INVERT_EN
  assign hit = (rd_data < thres_q);
`else
  assign hit = (rd_data >= thres_q);
`endif

  assign bin_data      = out_valid & hit;
  assign pixel_address = out_addr;
  assign condition_led = state;

endmodule

// File: tb/tb_binarization.sv
// Directed bench for binarization on a reduced 512-pixel frame so every pass fits the cycle budget.
module tb_binarization;

  localparam int ADDR_W = 9;
  localparam int N      = 1 << ADDR_W;

  logic              bin_clk = 1'b0;
  logic              bin_rst;
  logic              int_ctrl;
  logic              bin_ctrl;
  logic [7:0]        thres_length;
  logic [ADDR_W-1:0] pixel_address;
  logic              bin_data;
  logic [1:0]        condition_led;

  int   n_checks = 0;
  int   n_errors = 0;
  logic res [N];
  int   bin_cnt;
  int   seq_err;
  bit   aborted;

  binarization #(.ADDR_W(ADDR_W)) dut (
    .bin_clk       (bin_clk),
    .bin_rst       (bin_rst),
    .int_ctrl      (int_ctrl),
    .bin_ctrl      (bin_ctrl),
    .thres_length  (thres_length),
    .pixel_address (pixel_address),
    .bin_data      (bin_data),
    .condition_led (condition_led)
  );

  always #5 bin_clk = ~bin_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int a);
    return 8'((a & 255) + ((a >> 8) & 255));
  endfunction

  function automatic logic exp_bit(input int a, input logic [7:0] t);
`ifdef BIN_INVERT_EN
    return pix(a) < t;
`else
    return pix(a) >= t;
`endif
  endfunction

  task automatic tick();
    @(posedge bin_clk);
    #1;
  endtask

  task automatic run_init();
    int cnt = 0;
    int_ctrl = 1'b1;
    for (int c = 0; c < N + 50; c++) begin
      tick();
      if (c == 9) int_ctrl = 1'b0;
      if (condition_led == 2'b01) cnt++;
      else if (cnt > 0) break;
    end
    int_ctrl = 1'b0;
    check("init_len", cnt, N);
    check("init_end_led", condition_led, 2'b11);
  endtask

  // One binarize pass; thr_mid is applied halfway, poke_int raises int_ctrl mid-pass,
  // rst_at > 0 asserts bin_rst at that BIN cycle and aborts the pass.
  task automatic run_bin(input logic [7:0] thr, input logic [7:0] thr_mid,
                         input bit poke_int, input int rst_at);
    thres_length = thr;
    bin_ctrl     = 1'b1;
    bin_cnt      = 0;
    seq_err      = 0;
    aborted      = 1'b0;
    for (int i = 0; i < N; i++) res[i] = 1'b0;
    for (int c = 0; c < N + 50; c++) begin
      tick();
      if (c == 9) bin_ctrl = 1'b0;
      if (condition_led != 2'b10) break;
      bin_cnt++;
      if (bin_cnt == 1) begin
        check("bin_first_out", {pixel_address, bin_data}, 0);
      end else begin
        if (pixel_address !== ADDR_W'(bin_cnt - 2)) seq_err++;
        res[pixel_address] = bin_data;
      end
      if (bin_cnt == N / 2) thres_length = thr_mid;
      if (poke_int && bin_cnt == 100) int_ctrl = 1'b1;
      if (poke_int && bin_cnt == 105) int_ctrl = 1'b0;
      if (rst_at > 0 && bin_cnt == rst_at) begin
        bin_rst = 1'b1;
        tick();
        check("midbin_rst_led", condition_led, 2'b00);
        check("midbin_rst_out", {pixel_address, bin_data}, 0);
        bin_rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    bin_ctrl = 1'b0;
    int_ctrl = 1'b0;
    if (!aborted) begin
      check("bin_len", bin_cnt, N + 1);
      check("bin_end_led", condition_led, 2'b11);
      check("bin_end_out", {pixel_address, bin_data}, 0);
      check("bin_addr_seq", seq_err, 0);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] thr);
    int err  = 0;
    for (int a = 0; a < N; a++)
      if (res[a] !== exp_bit(a, thr)) err++;
    check(tag, err, 0);
  endtask

  function automatic int ones_in_res();
    int n = 0;
    for (int a = 0; a < N; a++) if (res[a] === 1'b1) n++;
    return n;
  endfunction

  function automatic int ones_model(input logic [7:0] thr);
    int n = 0;
    for (int a = 0; a < N; a++) if (exp_bit(a, thr)) n++;
    return n;
  endfunction

  initial begin
    bin_rst      = 1'b1;
    int_ctrl     = 1'b0;
    bin_ctrl     = 1'b0;
    thres_length = 8'd0;
    repeat (3) tick();
    check("rst_led", condition_led, 2'b00);
    check("rst_addr", pixel_address, 0);
    check("rst_data", bin_data, 1'b0);
    bin_rst = 1'b0;
    tick();

    // Binarize before any fill must be ignored.
    bin_ctrl = 1'b1;
    repeat (3) tick();
    check("idle_bin_ignored", condition_led, 2'b00);
    bin_ctrl = 1'b0;
    repeat (2) tick();
    check("idle_still", condition_led, 2'b00);

    run_init();

    // Threshold 40, input changed to 200 mid-pass: latched value must hold.
    run_bin(8'd40, 8'd200, 1'b0, 0);
    check("px_000", res[0],   exp_bit(0, 8'd40));
    check("px_040", res[40],  exp_bit(40, 8'd40));
    check("px_039", res[39],  exp_bit(39, 8'd40));
    check("px_294", res[294], exp_bit(294, 8'd40));
    check("px_295", res[295], exp_bit(295, 8'd40));
    check("px_300_latched", res[300], exp_bit(300, 8'd40));
    check_all("all_thr40", 8'd40);

    run_bin(8'd0, 8'd0, 1'b0, 0);
    check_all("all_thr0", 8'd0);
    check("ones_thr0", ones_in_res(), ones_model(8'd0));

    // Threshold 255 with an init edge injected during BIN.
    run_bin(8'd255, 8'd255, 1'b1, 0);
    check_all("all_thr255", 8'd255);
    check("px_0ff_thr255", res[255], exp_bit(255, 8'd255));
    check("ones_thr255", ones_in_res(), ones_model(8'd255));
    repeat (5) tick();
    check("int_in_bin_ignored", condition_led, 2'b11);

    // Reset mid-pass, then binarize must stay ignored until a fresh fill.
    run_bin(8'd40, 8'd40, 1'b0, 50);
    bin_ctrl = 1'b1;
    repeat (3) tick();
    bin_ctrl = 1'b0;
    repeat (2) tick();
    check("post_rst_bin_ignored", condition_led, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
